// File: rtl/robot_motion_decoder.sv
// robot_motion_decoder: one-hot command FSM with ramped speed that flips direction only at standstill.
// Define ROBOT_ERR_COUNT_EN to add err_count, a saturating count of FAULT entries.
module robot_motion_decoder #(
    parameter logic [7:0] MAX_SPEED = 8'd200,
    parameter logic [7:0] RAMP_STEP = 8'd16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       forward,
    input  logic       stop,
    input  logic       reverse,
    output logic       motor_en,
    output logic       motor_dir,
    output logic [7:0] speed,
    output logic [2:0] state,
    output logic       seq_error,
    output logic       illegal_code
`ifdef ROBOT_ERR_COUNT_EN
    ,
    output logic [7:0] err_count
`endif
);
    typedef enum logic [2:0] {IDLE = 3'd0, FWD = 3'd1, HALT = 3'd2, REV = 3'd3, FAULT = 3'd4} state_t;
    state_t cur, nxt;
    logic is_f, is_s, is_r, illegal;
    logic want_dir, dir_nxt;
    logic [7:0] target, speed_nxt;
    assign is_f = {forward, stop, reverse} == 3'b100;
    assign is_s = {forward, stop, reverse} == 3'b010;
    assign is_r = {forward, stop, reverse} == 3'b001;
    assign illegal = !(is_f || is_s || is_r);
    assign state = cur;
    always_comb begin
        nxt = cur;
        if (illegal)
            nxt = FAULT;
        else
            case (cur)
                IDLE:    nxt = is_f ? FWD : is_s ? HALT : REV;
                FWD:     nxt = is_r ? FAULT : is_s ? HALT : FWD;
                HALT:    nxt = is_f ? FAULT : is_r ? REV : HALT;
                REV:     nxt = is_s ? FAULT : is_f ? FWD : REV;
                FAULT:   nxt = is_s ? HALT : FAULT;
                default: nxt = IDLE;
            endcase
    end
    // Target stays 0 until motor_dir matches the requested drive direction.
    always_comb begin
        want_dir = cur == REV ? 1'b1 : cur == FWD ? 1'b0 : motor_dir;
        dir_nxt = speed == 8'd0 ? want_dir : motor_dir;
        target = ((cur == FWD && !motor_dir) || (cur == REV && motor_dir)) ? MAX_SPEED : 8'd0;
        speed_nxt = speed;
        if (cur == FAULT)
            speed_nxt = 8'd0;
        else if (speed < target)
            speed_nxt = (target - speed > RAMP_STEP) ? speed + RAMP_STEP : target;
        else if (speed > target)
            speed_nxt = (speed - target > RAMP_STEP) ? speed - RAMP_STEP : target;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur          <= IDLE;
            speed        <= 8'd0;
            motor_en     <= 1'b0;
            motor_dir    <= 1'b0;
            seq_error    <= 1'b0;
            illegal_code <= 1'b0;
        end else begin
            cur          <= nxt;
            speed        <= speed_nxt;
            motor_en     <= speed_nxt != 8'd0;
            motor_dir    <= dir_nxt;
            seq_error    <= nxt == FAULT;
            illegal_code <= illegal;
        end
    end
`ifdef ROBOT_ERR_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_count <= 8'd0;
        else if (nxt == FAULT && cur != FAULT && err_count != 8'hff)
            err_count <= err_count + 8'd1;
    end
`endif
endmodule

// File: tb/tb_robot_motion_decoder.sv
// tb_robot_motion_decoder: vector table plus hand sequences, checked through an expected-result queue.
module tb_robot_motion_decoder;
    localparam logic [2:0] F = 3'b100, S = 3'b010, R = 3'b001;
    logic clk = 1'b0, rst_n = 1'b0, forward = 1'b0, stop = 1'b0, reverse = 1'b0;
    logic motor_en, motor_dir, seq_error, illegal_code;
    logic [7:0] speed;
    logic [2:0] state;
`ifdef ROBOT_ERR_COUNT_EN
    logic [7:0] err_count;
`endif
    typedef struct packed {
        logic [2:0] st;
        logic [7:0] spd;
        logic       dir;
        logic       en;
        logic       serr;
        logic       ill;
    } obs_t;
    typedef struct {
        logic [2:0] code;
        obs_t       exp;
    } vec_t;
    vec_t vecs[$];
    obs_t exp_q[$];
    int checks = 0, passed = 0;

    always #5 clk = ~clk;

    robot_motion_decoder dut (
        .clk(clk), .rst_n(rst_n), .forward(forward), .stop(stop), .reverse(reverse),
        .motor_en(motor_en), .motor_dir(motor_dir), .speed(speed), .state(state),
        .seq_error(seq_error), .illegal_code(illegal_code)
`ifdef ROBOT_ERR_COUNT_EN
        , .err_count(err_count)
`endif
    );

    function automatic logic [7:0] clip(int v);
        return 8'(v > 200 ? 200 : v < 0 ? 0 : v);
    endfunction

    function automatic obs_t mk(logic [2:0] st, logic [7:0] spd, logic dir, logic serr, logic ill);
        return '{st, spd, dir, spd != 8'd0, serr, ill};
    endfunction

    function automatic void add(logic [2:0] code, obs_t exp);
        vecs.push_back('{code, exp});
    endfunction

    task automatic check(string name, obs_t exp);
        obs_t g;
        g = '{state, speed, motor_dir, motor_en, seq_error, illegal_code};
        checks++;
        if (g === exp) passed++;
        else $display("FAIL %s: got st=%0d spd=%0d dir=%b en=%b serr=%b ill=%b, expected st=%0d spd=%0d dir=%b en=%b serr=%b ill=%b",
                      name, g.st, g.spd, g.dir, g.en, g.serr, g.ill, exp.st, exp.spd, exp.dir, exp.en, exp.serr, exp.ill);
    endtask

    task automatic step(string name, logic [2:0] code, obs_t exp);
        {forward, stop, reverse} = code;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        check(name, exp_q.pop_front());
    endtask

    task automatic do_reset(string name);
        rst_n = 1'b0;
        {forward, stop, reverse} = 3'b000;
        #1;
        check(name, mk(0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int n = 1; n <= 14; n++) add(F, mk(1, clip(16 * (n - 1)), 0, 0, 0));
        add(S, mk(2, 200, 0, 0, 0));
        for (int k = 1; k <= 13; k++) add(R, mk(3, clip(200 - 16 * k), 0, 0, 0));
        add(R, mk(3, 0, 1, 0, 0));
        for (int k = 1; k <= 13; k++) add(R, mk(3, clip(16 * k), 1, 0, 0));
        add(3'b110, mk(4, 200, 1, 1, 1));
        add(R, mk(4, 0, 1, 1, 0));
        add(F, mk(4, 0, 1, 1, 0));
        add(3'b000, mk(4, 0, 1, 1, 1));
        add(S, mk(2, 0, 1, 0, 0));
        add(S, mk(2, 0, 1, 0, 0));
        add(R, mk(3, 0, 1, 0, 0));
        add(R, mk(3, 16, 1, 0, 0));
        add(S, mk(4, 32, 1, 1, 0));
        add(S, mk(2, 0, 1, 0, 0));

        @(posedge clk);
        #1;
        do_reset("por");
        foreach (vecs[i]) step($sformatf("vec%0d", i), vecs[i].code, vecs[i].exp);

        do_reset("reset_from_halt");
        step("fwd1", F, mk(1, 0, 0, 0, 0));
        step("fwd2", F, mk(1, 16, 0, 0, 0));
        step("fwd3", F, mk(1, 32, 0, 0, 0));
        step("illegal_in_fwd", 3'b110, mk(4, 48, 0, 1, 1));
        step("fault_zero", F, mk(4, 0, 0, 1, 0));
        step("fault_exit", S, mk(2, 0, 0, 0, 0));
        step("halt_f", F, mk(4, 0, 0, 1, 0));
        step("fault_f", F, mk(4, 0, 0, 1, 0));
        step("fault_r", R, mk(4, 0, 0, 1, 0));
        step("fault_s", S, mk(2, 0, 0, 0, 0));
        step("halt_r", R, mk(3, 0, 0, 0, 0));
        step("rev_f_flip", F, mk(1, 0, 1, 0, 0));
        step("fwd_flip_back", F, mk(1, 0, 0, 0, 0));
        step("fwd_r_fault", R, mk(4, 16, 0, 1, 0));
        step("fault_s2", S, mk(2, 0, 0, 0, 0));

        do_reset("reset_pre_ramp");
        for (int n = 1; n <= 7; n++) step($sformatf("ramp%0d", n), F, mk(1, clip(16 * (n - 1)), 0, 0, 0));
        do_reset("reset_mid_ramp");
        step("idle_r", R, mk(3, 0, 0, 0, 0));
        step("idle_r_dir", R, mk(3, 0, 1, 0, 0));
        step("idle_r_ramp1", R, mk(3, 16, 1, 0, 0));
        step("idle_r_ramp2", R, mk(3, 32, 1, 0, 0));

`ifdef ROBOT_ERR_COUNT_EN
        for (int i = 0; i < 300; i++) begin
            {forward, stop, reverse} = 3'b110;
            @(posedge clk);
            #1;
            {forward, stop, reverse} = S;
            @(posedge clk);
            #1;
        end
        checks++;
        if (err_count === 8'd255) passed++;
        else $display("FAIL err_sat: got %0d expected 255", err_count);
        rst_n = 1'b0;
        #1;
        checks++;
        if (err_count === 8'd0) passed++;
        else $display("FAIL err_reset: got %0d expected 0", err_count);
        rst_n = 1'b1;
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/robot_motion_decoder.md
ROBOT_MOTION_DECODER -- requirements
Module: robot_motion_decoder

Interface
REQ-001 Parameter MAX_SPEED, default 8'd200, SHALL set the speed ceiling (1..255).
REQ-002 Parameter RAMP_STEP, default 8'd16, SHALL set the per-cycle speed change (1..255).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 forward  input  1  SHALL be the forward command light.
REQ-006 stop  input  1  SHALL be the stop command light.
REQ-007 reverse  input  1  SHALL be the reverse command light.
REQ-008 motor_en  output  1  SHALL be high when speed is nonzero.
REQ-009 motor_dir  output  1  SHALL be the drive direction: 0 forward, 1 reverse.
REQ-010 speed  output  8  SHALL be the current ramped drive speed.
REQ-011 state  output  3  SHALL be the FSM state: IDLE=0, FWD=1, HALT=2, REV=3, FAULT=4.
REQ-012 seq_error  output  1  SHALL be high throughout the FAULT state.
REQ-013 illegal_code  output  1  SHALL be a 1-cycle pulse flagging a non-one-hot input.

Function
REQ-014 The decoder SHALL sample {forward,stop,reverse} every cycle; legal codes are 100 (F), 010 (S) and 001 (R); all other codes are illegal.
REQ-015 All outputs SHALL be registered; the state SHALL update on the cycle after the code is sampled; speed and motor_dir SHALL react from the following cycle onward.
REQ-016 IDLE SHALL move to FWD on F, to HALT on S and to REV on R; an illegal code SHALL move it to FAULT.
REQ-017 The legal sequence SHALL be F->S->R->F; repeating the current code SHALL hold the state.
REQ-018 FWD SHALL move to HALT on S, HALT to REV on R and REV to FWD on F.
REQ-019 Any out-of-order legal code (FWD+R, HALT+F, REV+S) SHALL move the FSM to FAULT.
REQ-020 An illegal code in any state SHALL move the FSM to FAULT and pulse illegal_code for exactly one cycle, once per illegal sample.
REQ-021 FAULT SHALL force speed to 0 on its first cycle, keep motor_en=0, and exit only on S (to HALT, seq_error clears); F, R and illegal codes SHALL keep it in FAULT.
REQ-022 Speed target SHALL be:
- MAX_SPEED in FWD when motor_dir=0, or in REV when motor_dir=1;
- 0 otherwise.
REQ-023 Speed SHALL step toward the target by RAMP_STEP per cycle, saturating exactly at the target with no overshoot and no 8-bit wrap.
REQ-024 motor_dir SHALL change only in a cycle where speed==0; a direction request at nonzero speed SHALL first ramp the speed to 0.
REQ-025 Entering REV directly from IDLE SHALL set motor_dir=1 once speed==0, which holds immediately after reset.

Reset
REQ-026 rst_n low SHALL immediately force state=IDLE, speed=0, motor_en=0, motor_dir=0, seq_error=0 and illegal_code=0, and clear the error counter.
REQ-027 Reset asserted mid-ramp or in FAULT SHALL abandon all activity; after deassertion the block SHALL restart from IDLE.

Configuration
REQ-028 With macro ROBOT_ERR_COUNT_EN defined, an extra output err_count (8 bits) SHALL count entries into FAULT, saturating at 255 and clearing on reset.
REQ-029 Without ROBOT_ERR_COUNT_EN, err_count and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-030 Reset, then F held for 14 cycles -> state=FWD; speed 16,32,...,192, then 200 held; motor_en=1, motor_dir=0.
REQ-031 From speed 200 in FWD: S, then R -> speed ramps down to 0 in 13 steps; motor_dir becomes 1 only at speed 0; speed then ramps to 200 in REV.
REQ-032 In FWD, apply 110 for one cycle -> illegal_code pulses once; state=FAULT; speed=0 the next cycle; seq_error=1 until S is applied, then state=HALT.
REQ-033 In HALT, apply F -> FAULT; a further F or R keeps FAULT; S -> HALT with seq_error=0.
REQ-034 Assert rst_n low mid-ramp at speed 96 -> all outputs zero immediately; after release, R -> state=REV, motor_dir=1, speed ramps from 0.
REQ-035 With ROBOT_ERR_COUNT_EN: 300 FAULT entries -> err_count=255 held; reset -> 0.
